// File: rtl/sensor_conditioner_pkg.sv
// Shared constants for the irrigation input front-end: default filter timing,
// channel map and display-select encodings.
package sensor_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int SYNC_STAGES_DEF     = 2;

  // Channel order on the internal vectors; the button is always the top bit.
  localparam int N_SENSORS  = 6;
  localparam int N_CHANNELS = 7;
  localparam int CH_HIGH    = 0;
  localparam int CH_MIDDLE  = 1;
  localparam int CH_LOW     = 2;
  localparam int CH_SOLO    = 3;
  localparam int CH_AR      = 4;
  localparam int CH_TEMP    = 5;
  localparam int CH_BOTAO   = 6;

  typedef enum logic {
    SEL_NIVEL     = 1'b0,
    SEL_IRRIGACAO = 1'b1
  } sel_e;

  function automatic sel_e sel_toggle(input sel_e cur);
    return (cur == SEL_NIVEL) ? SEL_IRRIGACAO : SEL_NIVEL;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One input channel: multi-stage synchroniser followed by a stability counter
// that only accepts a new level after DEBOUNCE_CYCLES consecutive agreeing samples.
module sensor_debounce
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic q,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
    end
  end

  // The counter never passes CNT_LAST: reaching it with a still-differing
  // sample commits the new level and clears in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (s == q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      q   <= s;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/sensor_conditioner.sv
// Board-pin front-end: seven debounced channels, push-button display selector,
// an all-quiet flag and a change pulse for the six sensor levels.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_high,
  input  logic raw_middle,
  input  logic raw_low,
  input  logic raw_umidadeDoSolo,
  input  logic raw_umidadeDoAr,
  input  logic raw_temperatura,
  input  logic raw_botao,
  output logic high,
  output logic middle,
  output logic low,
  output logic umidadeDoSolo,
  output logic umidadeDoAr,
  output logic temperatura,
  output logic seletor,
  output logic estavel,
  output logic mudanca
);

  // Display-select FSM
  //   state         | meaning
  //   SEL_NIVEL     | display shows tank level
  //   SEL_IRRIGACAO | display shows irrigation state

  logic [N_CHANNELS-1:0] raw_vec;
  logic [N_CHANNELS-1:0] q_vec;
  logic [N_CHANNELS-1:0] busy_vec;
  logic [N_SENSORS-1:0]  sens_q_d;
  logic                  botao_q_d;
  logic                  btn_rise;
  logic                  mudanca_q;
  logic                  estavel_q;
  sel_e                  sel_state;
  sel_e                  sel_next;

  assign raw_vec[CH_HIGH]   = raw_high;
  assign raw_vec[CH_MIDDLE] = raw_middle;
  assign raw_vec[CH_LOW]    = raw_low;
  assign raw_vec[CH_SOLO]   = raw_umidadeDoSolo;
  assign raw_vec[CH_AR]     = raw_umidadeDoAr;
  assign raw_vec[CH_TEMP]   = raw_temperatura;
  assign raw_vec[CH_BOTAO]  = raw_botao;

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .d_raw(raw_vec[i]),
      .q    (q_vec[i]),
      .busy (busy_vec[i])
    );
  end

  assign high          = q_vec[CH_HIGH];
  assign middle        = q_vec[CH_MIDDLE];
  assign low           = q_vec[CH_LOW];
  assign umidadeDoSolo = q_vec[CH_SOLO];
  assign umidadeDoAr   = q_vec[CH_AR];
  assign temperatura   = q_vec[CH_TEMP];

  assign btn_rise = q_vec[CH_BOTAO] & ~botao_q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_state <= SEL_NIVEL;
    end else begin
      sel_state <= sel_next;
    end
  end

  always_comb begin
    sel_next = sel_state;
    if (btn_rise) begin
      sel_next = sel_toggle(sel_state);
    end
  end

  // Driving from the next state makes the toggle visible on the same edge
  // that commits the debounced press; all inputs to this path are flops.
  always_comb begin
    seletor = logic'(sel_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_q_d  <= '0;
      botao_q_d <= 1'b0;
      mudanca_q <= 1'b0;
      estavel_q <= 1'b1;
    end else begin
      sens_q_d  <= q_vec[N_SENSORS-1:0];
      botao_q_d <= q_vec[CH_BOTAO];
      mudanca_q <= (q_vec[N_SENSORS-1:0] != sens_q_d);
      estavel_q <= ~|busy_vec;
    end
  end

  assign mudanca = mudanca_q;
  assign estavel = estavel_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_sensor_conditioner;

  localparam int DC = 4;
  localparam int SS = 2;

  typedef struct {
    logic [6:0] raw;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [6:0] raw = '0;
  logic high, middle, low, umidadeDoSolo, umidadeDoAr, temperatura;
  logic seletor, estavel, mudanca;
  logic [8:0] act;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sensor_conditioner #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .raw_high         (raw[0]),
    .raw_middle       (raw[1]),
    .raw_low          (raw[2]),
    .raw_umidadeDoSolo(raw[3]),
    .raw_umidadeDoAr  (raw[4]),
    .raw_temperatura  (raw[5]),
    .raw_botao        (raw[6]),
    .high             (high),
    .middle           (middle),
    .low              (low),
    .umidadeDoSolo    (umidadeDoSolo),
    .umidadeDoAr      (umidadeDoAr),
    .temperatura      (temperatura),
    .seletor          (seletor),
    .estavel          (estavel),
    .mudanca          (mudanca)
  );

  assign act = {mudanca, estavel, seletor, temperatura, umidadeDoAr, umidadeDoSolo, low, middle, high};

  function automatic logic [8:0] ex(input bit mud, input bit est, input bit sel, input logic [5:0] sens);
    return {mud, est, sel, sens};
  endfunction

  task automatic check(input string name, input logic [8:0] exp, input logic [8:0] mask = 9'h1FF);
    n_cmp++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got %b required %b (mask %b; order mud,est,sel,temp,ar,solo,low,mid,high)",
               name, act, exp, mask);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Glitch on raw_low: three sync'd samples, never accepted.
    tbl[0]  = '{7'h04, ex(0, 1, 0, 6'h00)};
    tbl[1]  = '{7'h04, ex(0, 1, 0, 6'h00)};
    tbl[2]  = '{7'h04, ex(0, 1, 0, 6'h00)};
    tbl[3]  = '{7'h00, ex(0, 0, 0, 6'h00)};
    tbl[4]  = '{7'h00, ex(0, 0, 0, 6'h00)};
    tbl[5]  = '{7'h00, ex(0, 0, 0, 6'h00)};
    tbl[6]  = '{7'h00, ex(0, 1, 0, 6'h00)};
    tbl[7]  = '{7'h00, ex(0, 1, 0, 6'h00)};
    // Soil humidity and temperature rise together.
    tbl[8]  = '{7'h28, ex(0, 1, 0, 6'h00)};
    tbl[9]  = '{7'h28, ex(0, 1, 0, 6'h00)};
    tbl[10] = '{7'h28, ex(0, 1, 0, 6'h00)};
    tbl[11] = '{7'h28, ex(0, 0, 0, 6'h00)};
    tbl[12] = '{7'h28, ex(0, 0, 0, 6'h00)};
    tbl[13] = '{7'h28, ex(0, 0, 0, 6'h28)};
    tbl[14] = '{7'h28, ex(1, 1, 0, 6'h28)};
    tbl[15] = '{7'h28, ex(0, 1, 0, 6'h28)};

    // 1. Reset with all raw pins high, then release.
    raw = 7'h7F;
    #1 rst_n = 1'b0;
    #1 check("t1_reset_state", ex(0, 1, 0, 6'h00));
    tick();
    tick();
    check("t1_reset_hold", ex(0, 1, 0, 6'h00));
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check($sformatf("t1_release_c%0d", t),
            ex(t == 7, !(t >= 4 && t <= 6), t >= 6, (t >= 6) ? 6'h3F : 6'h00));
    end

    raw = 7'h00;
    rst_n = 1'b0;
    #1 check("clean_reset_async", ex(0, 1, 0, 6'h00));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("clean_idle", ex(0, 1, 0, 6'h00));

    // 2 and 4. Table-driven glitch and simultaneous-change vectors.
    for (int i = 0; i < 16; i++) begin
      raw = tbl[i].raw;
      tick();
      check($sformatf("tbl_row%0d", i), tbl[i].exp);
    end

    // 3. Bounce on raw_middle: toggles every 2 cycles for 10 cycles, then holds 1.
    for (int t = 1; t <= 20; t++) begin
      raw = 7'h28 | ((t > 10 || ((t - 1) / 2) % 2 == 0) ? 7'h02 : 7'h00);
      tick();
      check($sformatf("t3_bounce_c%0d", t),
            ex(t == 15, 1'b1, 1'b0, (t >= 14) ? 6'h2A : 6'h28),
            (t >= 15) ? 9'h1FF : 9'h17F);
    end

    // 5. Button: press 20 cycles, release 20, press 20 again, release.
    for (int t = 1; t <= 70; t++) begin
      raw = 7'h2A | ((t <= 20 || (t >= 41 && t <= 60)) ? 7'h40 : 7'h00);
      tick();
      check($sformatf("t5_button_c%0d", t),
            ex(1'b0, 1'b1, (t >= 6 && t < 46), 6'h2A), 9'h17F);
    end

    // 6. Reset in the middle of a raw_high debounce.
    raw = 7'h00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_idle", ex(0, 1, 0, 6'h00));
    raw = 7'h01;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1 check("t6_reset_asserted", ex(0, 1, 0, 6'h00));
    tick();
    tick();
    check("t6_reset_held", ex(0, 1, 0, 6'h00));
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check($sformatf("t6_release_c%0d", t),
            ex(t == 7, !(t >= 4 && t <= 6), 1'b0, (t >= 6) ? 6'h01 : 6'h00));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
